// File: rtl/alu_sequencer_if.sv
// Instruction handshake and ALU operand/result bus between an instruction source,
// the sequencer, and the external combinational ALU.
interface alu_sequencer_if;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InOpcode;
    logic [3:0]  InRd;
    logic [3:0]  InRs;
    logic        InImmSel;
    logic [15:0] InImm;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic [4:0]  AluOpcode;
    logic        AluCin;
    logic [15:0] AluC;
    logic [4:0]  AluFlags;

    modport slave (
        input  InValid, InOpcode, InRd, InRs, InImmSel, InImm, AluC, AluFlags,
        output InReady, AluA, AluB, AluOpcode, AluCin
    );

    modport master (
        output InValid, InOpcode, InRd, InRs, InImmSel, InImm, AluC, AluFlags,
        input  InReady, AluA, AluB, AluOpcode, AluCin
    );
endinterface

// File: rtl/alu_sequencer.sv
// Three-state (IDLE/EXEC/WB) controller that runs one ALU instruction at a time
// against a 16x16 register file and keeps a 5-bit processor status register.
module alu_sequencer #(
    parameter int NREGS     = 16,
    parameter int CARRY_BIT = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    alu_sequencer_if.slave       bus,
    output logic                 Done,
    output logic                 Err,
    output logic [4:0]           Psr,
    input  logic [3:0]           DbgAddr,
    output logic [15:0]          DbgData
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    function automatic logic op_supported(input logic [4:0] op);
        case (op)
            5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b01001, 5'b01100, 5'b10011, 5'b10111, 5'b01011: op_supported = 1'b1;
            default:                                          op_supported = 1'b0;
        endcase
    endfunction

    // CMP only updates flags; everything else that is supported writes Rd.
    function automatic logic op_writes_back(input logic [4:0] op);
        case (op)
            5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b01001, 5'b01100, 5'b10011, 5'b10111: op_writes_back = 1'b1;
            default:                                op_writes_back = 1'b0;
        endcase
    endfunction

    state_e       state_q, state_d;
    logic         ready_q, ready_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [15:0]  alu_a_q, alu_a_d;
    logic [15:0]  alu_b_q, alu_b_d;
    logic [4:0]   alu_op_q, alu_op_d;
    logic         alu_cin_q, alu_cin_d;
    logic [3:0]   rd_q, rd_d;
    logic [15:0]  res_q, res_d;
    logic [4:0]   flg_q, flg_d;
    logic [4:0]   psr_q, psr_d;
    logic         wr_en_s;
    logic [15:0]  regs_q [NREGS];

    // Next-state and datapath control for the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        rd_d     = rd_q;
        res_d    = res_q;
        flg_d    = flg_q;
        psr_d    = psr_q;
        wr_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.InValid) begin
                    state_d  = ST_EXEC;
                    alu_a_d  = regs_q[bus.InRd];
                    alu_b_d  = bus.InImmSel ? bus.InImm : regs_q[bus.InRs];
                    alu_op_d = bus.InOpcode;
                    rd_d     = bus.InRd;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
                res_d   = bus.AluC;
                flg_d   = bus.AluFlags;
                done_d  = 1'b1;
                err_d   = ~op_supported(alu_op_q);
            end
            ST_WB: begin
                state_d = ST_IDLE;
                wr_en_s = op_writes_back(alu_op_q);
                if (op_supported(alu_op_q)) begin
                    psr_d = flg_q;
                end else begin
                    psr_d = psr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered, so derive them from where the FSM is heading.
        ready_d   = (state_d == ST_IDLE);
        alu_cin_d = psr_d[CARRY_BIT];
    end

    // State, operand, result and status registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            alu_a_q   <= 16'h0000;
            alu_b_q   <= 16'h0000;
            alu_op_q  <= 5'b00000;
            alu_cin_q <= 1'b0;
            rd_q      <= 4'h0;
            res_q     <= 16'h0000;
            flg_q     <= 5'b00000;
            psr_q     <= 5'b00000;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            alu_cin_q <= alu_cin_d;
            rd_q      <= rd_d;
            res_q     <= res_d;
            flg_q     <= flg_d;
            psr_q     <= psr_d;
        end
    end

    // General register file, written at the close of WB.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            if (wr_en_s) begin
                regs_q[rd_q] <= res_q;
            end
        end
    end

    assign bus.InReady   = ready_q;
    assign bus.AluA      = alu_a_q;
    assign bus.AluB      = alu_b_q;
    assign bus.AluOpcode = alu_op_q;
    assign bus.AluCin    = alu_cin_q;
    assign Done          = done_q;
    assign Err           = err_q;
    assign Psr           = psr_q;
    assign DbgData       = regs_q[DbgAddr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU stub on the bus.
module tb_alu_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Done, Err;
    logic [4:0]  Psr;
    logic [3:0]  DbgAddr = 4'h0;
    logic [15:0] DbgData;
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    alu_sequencer_if bus ();

    alu_sequencer #(.NREGS(16), .CARRY_BIT(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave),
        .Done    (Done),
        .Err     (Err),
        .Psr     (Psr),
        .DbgAddr (DbgAddr),
        .DbgData (DbgData)
    );

    always #5 Clk = ~Clk;

    // ALU stub; flags are {C, N, F(overflow), Z, L}.
    always_comb begin
        logic [16:0] sum;
        bus.AluC     = 16'h0000;
        bus.AluFlags = 5'b00000;
        sum          = 17'h00000;
        case (bus.AluOpcode)
            5'b00001: bus.AluC = bus.AluA & bus.AluB;
            5'b00010: bus.AluC = bus.AluA | bus.AluB;
            5'b00011: bus.AluC = bus.AluA ^ bus.AluB;
            5'b00100: bus.AluC = ~bus.AluA;
            5'b00101: begin
                sum = {1'b0, bus.AluA} + {1'b0, bus.AluB} + {16'h0000, bus.AluCin};
                bus.AluC = sum[15:0];
                bus.AluFlags[4] = sum[16];
                bus.AluFlags[2] = (bus.AluA[15] == bus.AluB[15]) && (sum[15] != bus.AluA[15]);
            end
            5'b01001: begin
                sum = {1'b0, bus.AluA} + {1'b0, ~bus.AluB} + 17'h00001;
                bus.AluC = sum[15:0];
                bus.AluFlags[4] = sum[16];
                bus.AluFlags[2] = (bus.AluA[15] != bus.AluB[15]) && (sum[15] != bus.AluA[15]);
            end
            5'b01100: bus.AluC = bus.AluA << bus.AluB[3:0];
            5'b10011: bus.AluC = bus.AluA >> bus.AluB[3:0];
            5'b10111: bus.AluC = $signed(bus.AluA) >>> bus.AluB[3:0];
            default:  bus.AluC = 16'h0000;
        endcase
        if (bus.AluOpcode == 5'b01011) begin
            bus.AluFlags[1] = (bus.AluA == bus.AluB);
            bus.AluFlags[0] = (bus.AluA < bus.AluB);
            bus.AluFlags[3] = ($signed(bus.AluA) < $signed(bus.AluB));
        end else begin
            bus.AluFlags[1] = (bus.AluC == 16'h0000);
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [3:0] addr, input logic [15:0] exp, input string tag);
        DbgAddr = addr;
        #1;
        check(tag, DbgData, exp);
    endtask

    // Issue one instruction and check the EXEC / WB / return-to-IDLE cycles.
    task automatic run(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic isel, input logic [15:0] imm, input logic hold,
                       input logic exp_err, input logic exp_cin,
                       input logic [15:0] exp_a, input logic [15:0] exp_b, input string tag);
        int waited = 0;
        @(negedge Clk);
        while (bus.InReady !== 1'b1 && waited < 10) begin
            @(negedge Clk);
            waited++;
        end
        check({tag, "/ready_before"}, 16'(bus.InReady), 16'h0001);
        bus.InOpcode = op;
        bus.InRd     = rd;
        bus.InRs     = rs;
        bus.InImmSel = isel;
        bus.InImm    = imm;
        bus.InValid  = 1'b1;
        @(posedge Clk);
        #1;
        if (!hold) bus.InValid = 1'b0;
        @(negedge Clk);
        check({tag, "/exec_ready"}, 16'(bus.InReady), 16'h0000);
        check({tag, "/exec_done"}, 16'(Done), 16'h0000);
        check({tag, "/exec_a"}, bus.AluA, exp_a);
        check({tag, "/exec_b"}, bus.AluB, exp_b);
        check({tag, "/exec_op"}, 16'(bus.AluOpcode), 16'(op));
        check({tag, "/exec_cin"}, 16'(bus.AluCin), 16'(exp_cin));
        @(negedge Clk);
        check({tag, "/wb_done"}, 16'(Done), 16'h0001);
        check({tag, "/wb_err"}, 16'(Err), 16'(exp_err));
        check({tag, "/wb_ready"}, 16'(bus.InReady), 16'h0000);
        bus.InValid = 1'b0;
        @(negedge Clk);
        check({tag, "/idle_done"}, 16'(Done), 16'h0000);
        check({tag, "/idle_err"}, 16'(Err), 16'h0000);
        check({tag, "/idle_ready"}, 16'(bus.InReady), 16'h0001);
    endtask

    initial begin
        bus.InValid  = 1'b0;
        bus.InOpcode = 5'b00000;
        bus.InRd     = 4'h0;
        bus.InRs     = 4'h0;
        bus.InImmSel = 1'b0;
        bus.InImm    = 16'h0000;

        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check("rst/ready", 16'(bus.InReady), 16'h0001);
        check("rst/psr", 16'(Psr), 16'h0000);
        check("rst/done", 16'(Done), 16'h0000);
        check("rst/err", 16'(Err), 16'h0000);
        check("rst/alu_a", bus.AluA, 16'h0000);
        check("rst/alu_b", bus.AluB, 16'h0000);
        check("rst/alu_op", 16'(bus.AluOpcode), 16'h0000);
        for (int i = 0; i < 16; i++) begin
            chk_reg(4'(i), 16'h0000, $sformatf("rst/reg%0d", i));
        end

        // R1 = 0 | 0402, then R1 += 1325
        run(5'b00010, 4'd1, 4'd0, 1'b1, 16'h0402, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0402, "or_r1");
        chk_reg(4'd1, 16'h0402, "or_r1/r1");
        run(5'b00101, 4'd1, 4'd0, 1'b1, 16'h1325, 1'b0, 1'b0, 1'b0, 16'h0402, 16'h1325, "add_r1");
        chk_reg(4'd1, 16'h1727, "add_r1/r1");
        check("add_r1/psr", 16'(Psr), 16'h0000);

        // CMP of equal registers
        run(5'b00010, 4'd2, 4'd0, 1'b1, 16'h7335, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7335, "or_r2");
        run(5'b00010, 4'd3, 4'd0, 1'b1, 16'h7335, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7335, "or_r3");
        run(5'b01011, 4'd2, 4'd3, 1'b0, 16'hdead, 1'b0, 1'b0, 1'b0, 16'h7335, 16'h7335, "cmp");
        chk_reg(4'd2, 16'h7335, "cmp/r2");
        check("cmp/psr", 16'(Psr), 16'h0002);

        // Arithmetic shift then NOT
        run(5'b00010, 4'd4, 4'd0, 1'b1, 16'h80ff, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h80ff, "or_r4");
        run(5'b10111, 4'd4, 4'd0, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h80ff, 16'h0004, "arsh");
        chk_reg(4'd4, 16'hf80f, "arsh/r4");
        check("arsh/psr", 16'(Psr), 16'h0000);
        run(5'b00100, 4'd4, 4'd0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hf80f, 16'h0000, "not");
        chk_reg(4'd4, 16'h07f0, "not/r4");

        // Carry out, then an unsupported opcode must leave R5 and Psr alone
        run(5'b00010, 4'd5, 4'd0, 1'b1, 16'hffff, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hffff, "or_r5");
        run(5'b00101, 4'd5, 4'd0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'hffff, 16'h0001, "add_carry");
        chk_reg(4'd5, 16'h0000, "add_carry/r5");
        check("add_carry/psr", 16'(Psr), 16'h0012);
        run(5'b11111, 4'd5, 4'd0, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1234, "bad_op");
        chk_reg(4'd5, 16'h0000, "bad_op/r5");
        check("bad_op/psr", 16'(Psr), 16'h0012);
        @(negedge Clk);
        check("bad_op/no_reaccept_ready", 16'(bus.InReady), 16'h0001);
        check("bad_op/no_reaccept_done", 16'(Done), 16'h0000);
        run(5'b00101, 4'd5, 4'd0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, "add_cin");
        chk_reg(4'd5, 16'h0002, "add_cin/r5");
        check("add_cin/psr", 16'(Psr), 16'h0000);

        // Rd == Rs reads the pre-instruction value for both operands
        run(5'b00010, 4'd6, 4'd0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, "or_r6");
        run(5'b00101, 4'd6, 4'd6, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0003, "add_r6r6");
        chk_reg(4'd6, 16'h0006, "add_r6r6/r6");

        // Reset in the middle of EXEC drops the instruction
        @(negedge Clk);
        bus.InOpcode = 5'b00101;
        bus.InRd     = 4'd1;
        bus.InRs     = 4'd0;
        bus.InImmSel = 1'b1;
        bus.InImm    = 16'h0001;
        bus.InValid  = 1'b1;
        @(posedge Clk);
        #1;
        bus.InValid = 1'b0;
        Reset_n     = 1'b0;
        @(negedge Clk);
        check("mid_rst/done", 16'(Done), 16'h0000);
        check("mid_rst/ready", 16'(bus.InReady), 16'h0001);
        check("mid_rst/alu_a", bus.AluA, 16'h0000);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        chk_reg(4'd1, 16'h0000, "mid_rst/r1");
        chk_reg(4'd4, 16'h0000, "mid_rst/r4");
        check("mid_rst/psr", 16'(Psr), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check($sformatf("mid_rst/idle_ready%0d", i), 16'(bus.InReady), 16'h0001);
            check($sformatf("mid_rst/idle_done%0d", i), 16'(Done), 16'h0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
